// File: rtl/ibis_wfifo.sv
// ibis_wfifo: write-data buffer between the AXI4 slave and the Ibis core.
// Register-array FIFO with level count, almost-full flag and sticky overrun.
module ibis_wfifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overrun
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2;

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          afull_q, afull_d;
  logic          ovr_q, ovr_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wr_en;

  // Handshakes depend only on registered state, never on m_ready.
  always_comb begin
    full    = (level_q == LVL_FULL);
    empty   = (level_q == '0);
    s_ready = enable & ~areset & ~full;
    m_valid = enable & ~areset & ~empty;
    push    = s_valid & s_ready;
    pop     = m_valid & m_ready;
    wr_en   = push & ~flush;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovr_d   = ovr_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovr_d   = 1'b0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      if (s_valid && !s_ready && enable) begin
        ovr_d = 1'b1;
      end
    end
    afull_d = (level_d >= LVL_AFULL);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      afull_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      afull_q <= afull_d;
      ovr_q   <= ovr_d;
    end
  end

  // Storage is never cleared; push is already blocked during reset.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= s_data;
    end
  end

  assign m_data      = mem_q[rptr_q];
  assign level       = level_q;
  assign almost_full = afull_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_ibis_wfifo.sv
// tb_ibis_wfifo: directed vector table plus hand-written sequences
// for fill/drain/wrap, overrun, simultaneous push/pop and resets.
module tb_ibis_wfifo;

  logic        aclk;
  logic        areset;
  logic        enable;
  logic        flush;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  level;
  logic        almost_full;
  logic        overrun;

  int checks;
  int failures;

  ibis_wfifo #(
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (4),
    .AFULL_LEVEL(12)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .flush      (flush),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .almost_full(almost_full),
    .overrun    (overrun)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        fl;
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic [4:0]  lvl;
    logic        mv;
    logic        sr;
    logic        af;
    logic        ov;
    logic        chkd;
    logic [31:0] md;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic fl,
                      input logic sv, input logic [31:0] sd,
                      input logic mr);
    areset  = rst;
    enable  = en;
    flush   = fl;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [4:0] lvl,
                           input logic mv, input logic sr,
                           input logic af, input logic ov);
    chk({tag, ".level"}, 32'(level), 32'(lvl));
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(mv));
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(sr));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ov));
  endtask

  function automatic vec_t mk(logic rst, logic en, logic fl, logic sv,
                              logic [31:0] sd, logic mr, logic [4:0] lvl,
                              logic mv, logic sr, logic af, logic ov,
                              logic chkd, logic [31:0] md);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.sv = sv; v.sd = sd; v.mr = mr;
    v.lvl = lvl; v.mv = mv; v.sr = sr; v.af = af; v.ov = ov;
    v.chkd = chkd; v.md = md;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    areset   = 1'b1;
    enable   = 1'b1;
    flush    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;

    // Reset, latency, level-1 push+pop, enable gating, flush.
    //            rst en fl sv sd            mr lvl mv sr af ov chkd md
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hDEADBEEF, 0, 1, 1, 1, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 0, 1, 32'hA5,       1, 1, 1, 1, 0, 0, 1, 32'hA5));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h11,       0, 1, 1, 1, 0, 0, 1, 32'h11));
    vecs.push_back(mk(0, 1, 0, 1, 32'h22,       0, 2, 1, 1, 0, 0, 1, 32'h11));
    vecs.push_back(mk(0, 1, 0, 1, 32'h33,       0, 3, 1, 1, 0, 0, 1, 32'h11));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 1, 32'h44,     1, 3, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 2, 1, 1, 0, 0, 1, 32'h22));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 0, 0, 1, 32'h33));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0, 1, 0, 1, 32'(i),     0, 5'(i), 1, 1, 0, 0, 1, 32'h1));
    vecs.push_back(mk(0, 1, 1, 1, 32'h66,       1, 0, 0, 1, 0, 0, 0, 32'h0));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].en, vecs[k].fl, vecs[k].sv,
           vecs[k].sd, vecs[k].mr);
      chk_state($sformatf("vec%0d", k), vecs[k].lvl, vecs[k].mv,
                vecs[k].sr, vecs[k].af, vecs[k].ov);
      if (vecs[k].chkd)
        chk($sformatf("vec%0d.m_data", k), m_data, vecs[k].md);
    end

    // Fill to full, watching almost_full from level 12.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 1, 32'(i), 0);
      chk_state($sformatf("fill%0d", i), 5'(i + 1), 1'b1, (i + 1) < 16,
                (i + 1) >= 12, 1'b0);
    end

    // Overrun on full, sticky across idle cycles.
    step(0, 1, 0, 1, 32'h99, 0);
    chk_state("ovr_set", 5'd16, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("ovr_set.m_data", m_data, 32'h0);
    step(0, 1, 0, 0, 32'h0, 0);
    chk_state("ovr_hold", 5'd16, 1'b1, 1'b0, 1'b1, 1'b1);

    // Drain in order; s_ready returns with level 15.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.m_data", i), m_data, 32'(i));
      step(0, 1, 0, 0, 32'h0, 1);
      chk_state($sformatf("drain%0d", i), 5'(15 - i), i < 15, 1'b1,
                (15 - i) >= 12, 1'b1);
    end
    step(0, 1, 1, 0, 32'h0, 0);
    chk_state("flush_ovr", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 40 words streamed through at level 1: pointers wrap twice.
    step(0, 1, 0, 1, 32'h100, 0);
    for (int i = 1; i < 40; i++) begin
      step(0, 1, 0, 1, 32'h100 + 32'(i), 1);
      chk($sformatf("wrap%0d.level", i), 32'(level), 32'd1);
      chk($sformatf("wrap%0d.m_data", i), m_data, 32'h100 + 32'(i));
    end
    step(0, 1, 0, 0, 32'h0, 1);
    chk_state("wrap_end", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Simultaneous push and pop at level 8.
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 1, 32'h200 + 32'(i), 0);
    step(0, 1, 0, 1, 32'h2FF, 1);
    chk_state("pp8", 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pp8.m_data", m_data, 32'h201);
    step(0, 1, 1, 0, 32'h0, 0);
    chk_state("pp8_flush", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream at level 5.
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 1, 32'h300 + 32'(i), 0);
    chk_state("pre_rst", 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1, 1, 0, 1, 32'h3FF, 1);
    chk_state("rst_mid", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 1, 0, 0, 32'h0, 0);
    chk_state("post_rst", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 1, 0, 1, 32'h400, 0);
    chk_state("post_rst_push", 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_rst_push.m_data", m_data, 32'h400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
